// File: rtl/cache_line_axi_bridge_pkg.sv
// Shared AXI encodings, FSM state types and line/word types used by the cache line bridge.
package cache_line_axi_bridge_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam int unsigned DEF_LINE_WORDS = 4;

  typedef logic [31:0] word_t;
  typedef word_t [DEF_LINE_WORDS-1:0] line_t;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_RET} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_B}   wr_state_e;

  // Byte offset width of a line: word index bits plus the two byte-in-word bits.
  function automatic int unsigned line_ofs(input int unsigned line_words);
    return $clog2(line_words) + 2;
  endfunction

endpackage

// File: rtl/cache_line_axi_bridge_line_beat_buffer.sv
// LINE_WORDS x 32 register array: word-indexed write, full-line load, word-indexed read.
module cache_line_axi_bridge_line_beat_buffer
  import cache_line_axi_bridge_pkg::*;
#(
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          i_wr_en,
  input  logic [$clog2(LINE_WORDS)-1:0] i_wr_idx,
  input  word_t                         i_wr_word,
  input  logic                          i_load_en,
  input  logic [32*LINE_WORDS-1:0]      i_load_line,
  input  logic [$clog2(LINE_WORDS)-1:0] i_rd_idx,
  output word_t                         o_rd_word,
  output logic [32*LINE_WORDS-1:0]      o_line
);

  word_t [LINE_WORDS-1:0] r_mem;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem <= '0;
    end else if (i_load_en) begin
      r_mem <= i_load_line;
    end else if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_word;
    end
  end

  assign o_rd_word = r_mem[i_rd_idx];
  assign o_line    = r_mem;

endmodule

// File: rtl/cache_line_axi_bridge.sv
// Cache line refill/writeback to AXI4 INCR burst bridge with independent read and write
// channels, bus error reporting and read-after-writeback ordering on the same line.
module cache_line_axi_bridge
  import cache_line_axi_bridge_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int ID_W       = 4,
  parameter int RD_ID      = 0,
  parameter int WR_ID      = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    rd_req,
  input  logic [31:0]             rd_addr,
  output logic                    rd_rdy,
  output logic                    ret_valid,
  output logic [32*LINE_WORDS-1:0] ret_data,
  input  logic                    wr_req,
  input  logic [31:0]             wr_addr,
  input  logic [32*LINE_WORDS-1:0] wr_data,
  output logic                    wr_rdy,
  output logic                    wr_valid,
  output logic                    bus_err,
  output logic [ID_W-1:0]         arid,
  output logic [31:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [ID_W-1:0]         rid,
  input  logic [31:0]             rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [ID_W-1:0]         awid,
  output logic [31:0]             awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [31:0]             wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [ID_W-1:0]         bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam int LINE_BITS = 32 * LINE_WORDS;
  localparam int OFS       = line_ofs(LINE_WORDS);
  localparam int IDX_W     = $clog2(LINE_WORDS);
  localparam int TAG_W     = 32 - OFS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  rd_state_e        r_rstate;
  logic [TAG_W-1:0] r_rtag;
  logic [IDX_W-1:0] r_rcnt;
  logic             r_arvalid;
  logic             r_rready;
  logic             r_ret_valid;
  logic             r_rerr;

  wr_state_e        r_wstate;
  logic [TAG_W-1:0] r_wtag;
  logic [IDX_W-1:0] r_wcnt;
  logic             r_wr_rdy;
  logic             r_awvalid;
  logic             r_wvalid;
  logic             r_bready;

  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_hazard;
  logic             w_rd_beat;
  logic             w_rfinal;
  logic             w_w_beat;
  logic             w_b_hs;
  logic [LINE_BITS-1:0] w_rline;
  word_t            w_wword;
  word_t            w_unused_rword;
  logic [LINE_BITS-1:0] w_unused_wline;
  logic             w_unused;

  // A read must not overtake a pending or same-cycle writeback of its own line.
  assign w_wr_acc  = wr_req && r_wr_rdy;
  assign w_hazard  = ((r_wstate != W_IDLE) && (r_wtag == rd_addr[31:OFS])) ||
                     (w_wr_acc && (wr_addr[31:OFS] == rd_addr[31:OFS]));
  assign rd_rdy    = (r_rstate == R_IDLE) && !w_hazard;
  assign w_rd_acc  = rd_req && rd_rdy;

  assign w_rd_beat = (r_rstate == R_DATA) && rvalid;
  assign w_rfinal  = rlast || (r_rcnt == LAST_IDX);
  assign w_w_beat  = r_wvalid && wready;
  assign w_b_hs    = r_bready && bvalid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rstate    <= R_IDLE;
      r_rtag      <= '0;
      r_rcnt      <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_ret_valid <= 1'b0;
      r_rerr      <= 1'b0;
    end else begin
      r_ret_valid <= 1'b0;
      case (r_rstate)
        R_IDLE: begin
          if (w_rd_acc) begin
            r_rtag    <= rd_addr[31:OFS];
            r_rerr    <= 1'b0;
            r_arvalid <= 1'b1;
            r_rstate  <= R_AR;
          end
        end
        R_AR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_rcnt    <= '0;
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (w_rd_beat) begin
            r_rcnt <= r_rcnt + 1'b1;
            if (rresp != RESP_OKAY) begin
              r_rerr <= 1'b1;
            end
            if (w_rfinal) begin
              r_rready    <= 1'b0;
              r_ret_valid <= 1'b1;
              r_rstate    <= R_RET;
            end
          end
        end
        R_RET: begin
          r_rstate <= R_IDLE;
        end
        default: begin
          r_rstate <= R_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wstate  <= W_IDLE;
      r_wtag    <= '0;
      r_wcnt    <= '0;
      r_wr_rdy  <= 1'b1;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_wr_acc) begin
            r_wtag    <= wr_addr[31:OFS];
            r_wr_rdy  <= 1'b0;
            r_awvalid <= 1'b1;
            r_wstate  <= W_AW;
          end
        end
        W_AW: begin
          if (awready) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_wcnt    <= '0;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_beat) begin
            r_wcnt <= r_wcnt + 1'b1;
            if (r_wcnt == LAST_IDX) begin
              r_wvalid <= 1'b0;
              r_bready <= 1'b1;
              r_wstate <= W_B;
            end
          end
        end
        W_B: begin
          if (bvalid) begin
            r_bready <= 1'b0;
            r_wr_rdy <= 1'b1;
            r_wstate <= W_IDLE;
          end
        end
        default: begin
          r_wstate <= W_IDLE;
        end
      endcase
    end
  end

  cache_line_axi_bridge_line_beat_buffer #(
    .LINE_WORDS (LINE_WORDS)
  ) u_refill_buf (
    .clk         (clk),
    .resetn      (resetn),
    .i_wr_en     (w_rd_beat),
    .i_wr_idx    (r_rcnt),
    .i_wr_word   (rdata),
    .i_load_en   (1'b0),
    .i_load_line ('0),
    .i_rd_idx    ('0),
    .o_rd_word   (w_unused_rword),
    .o_line      (w_rline)
  );

  cache_line_axi_bridge_line_beat_buffer #(
    .LINE_WORDS (LINE_WORDS)
  ) u_wb_buf (
    .clk         (clk),
    .resetn      (resetn),
    .i_wr_en     (1'b0),
    .i_wr_idx    ('0),
    .i_wr_word   ('0),
    .i_load_en   (w_wr_acc),
    .i_load_line (wr_data),
    .i_rd_idx    (r_wcnt),
    .o_rd_word   (w_wword),
    .o_line      (w_unused_wline)
  );

  assign arid      = ID_W'(RD_ID);
  assign araddr    = {r_rtag, {OFS{1'b0}}};
  assign arlen     = 8'(LINE_WORDS - 1);
  assign arsize    = SIZE_4B;
  assign arburst   = BURST_INCR;
  assign arvalid   = r_arvalid;
  assign rready    = r_rready;
  assign ret_valid = r_ret_valid;
  assign ret_data  = w_rline;

  assign awid      = ID_W'(WR_ID);
  assign awaddr    = {r_wtag, {OFS{1'b0}}};
  assign awlen     = 8'(LINE_WORDS - 1);
  assign awsize    = SIZE_4B;
  assign awburst   = BURST_INCR;
  assign awvalid   = r_awvalid;
  assign wdata     = w_wword;
  assign wstrb     = 4'hF;
  assign wlast     = r_wvalid && (r_wcnt == LAST_IDX);
  assign wvalid    = r_wvalid;
  assign bready    = r_bready;
  assign wr_rdy    = r_wr_rdy;
  assign wr_valid  = w_b_hs;

  // Read errors are held until the final beat so one pulse covers the whole burst.
  assign bus_err   = (w_rd_beat && w_rfinal && (r_rerr || (rresp != RESP_OKAY))) ||
                     (w_b_hs && (bresp != RESP_OKAY));

  assign w_unused  = ^{rid, bid, rd_addr[OFS-1:0], wr_addr[OFS-1:0], w_unused_rword, w_unused_wline};

endmodule

// File: doc/cache_line_axi_bridge.md
Name: cache_line_axi_bridge

Overview:
- Converts cache line-refill and line-writeback requests into AXI4 INCR bursts.
- Cache side is the existing cache-to-AXI line handshake (rd_req/rd_rdy/ret_valid, wr_req/wr_rdy/wr_valid), generalised to a parametrised line width.
- Sits between I/D-cache miss logic and the top-level AXI crossbar.
- Adds over the current scheme: independent read/write channels, true burst sequencing, error reporting, read-after-writeback ordering on the same line.

Parameters:
- LINE_WORDS, 4, 32-bit words per cache line; power of 2, range 2..16. Localparam LINE_BITS = 32*LINE_WORDS, OFS = log2(LINE_WORDS)+2.
- ID_W, 4, AXI ID width.
- RD_ID, 0, constant ARID.
- WR_ID, 1, constant AWID.

Ports:
- clk in 1 system clock
- resetn in 1 asynchronous active-low reset
- rd_req in 1 line refill request
- rd_addr in 32 refill address; low OFS bits ignored
- rd_rdy out 1 refill request accepted this cycle when rd_req&rd_rdy
- ret_valid out 1 one-cycle pulse, ret_data valid
- ret_data out LINE_BITS refilled line; word k at [32k+31:32k]
- wr_req in 1 writeback request
- wr_addr in 32 writeback address; low OFS bits ignored
- wr_data in LINE_BITS writeback line, same word layout
- wr_rdy out 1 writeback accepted when wr_req&wr_rdy
- wr_valid out 1 one-cycle pulse on write response
- bus_err out 1 one-cycle pulse on RRESP/BRESP != OKAY
- arid/araddr/arlen/arsize/arburst/arvalid out ID_W/32/8/3/2/1; arready in 1
- rid/rdata/rresp/rlast/rvalid in ID_W/32/2/1/1; rready out 1
- awid/awaddr/awlen/awsize/awburst/awvalid out ID_W/32/8/3/2/1; awready in 1
- wdata/wstrb/wlast/wvalid out 32/4/1/1; wready in 1
- bid/bresp/bvalid in ID_W/2/1; bready out 1

Behaviour:
- Reset (async, resetn=0): both FSMs IDLE.
  - rd_rdy=1 and wr_rdy=1, except rd_rdy also obeys the hazard rule below.
  - All valids, ready outputs and pulses are 0; ret_data=0.
  - Reset mid-burst aborts without completing the AXI transaction; the system resets the interconnect together.
- Constant fields: arlen=awlen=LINE_WORDS-1, arsize=awsize=3'b010, arburst=awburst=2'b01, wstrb=4'hF.
  - araddr/awaddr = latched address with low OFS bits zeroed.
- Read FSM: R_IDLE -> R_AR -> R_DATA -> R_RET -> R_IDLE.
  - R_IDLE: rd_rdy = !hazard. On accept, latch the line address and go to R_AR.
  - R_AR: arvalid=1 until arready, then R_DATA with beat counter 0.
  - R_DATA: rready=1. Each rvalid beat writes rdata into word[counter] and increments counter.
  - On rlast, or when counter reaches LINE_WORDS-1, go to R_RET. A beat carrying both conditions is the final beat.
  - R_RET: ret_valid=1 for exactly one cycle, then R_IDLE. ret_data holds until the next accept.
  - Minimum accept-to-ret_valid latency: LINE_WORDS+2 cycles with arready and rvalid always high.
- Write FSM: W_IDLE -> W_AW -> W_DATA -> W_B -> W_IDLE.
  - W_IDLE: wr_rdy=1. On accept, latch the address and full line.
  - W_AW: awvalid=1 until awready. The AW handshake completes before the first W beat.
  - W_DATA: wvalid=1, wdata=word[counter]. Counter advances on each wready. wlast=1 when counter==LINE_WORDS-1; after that beat go to W_B.
  - W_B: bready=1. On bvalid, wr_valid pulses one cycle (combinationally with the handshake) and the FSM returns to W_IDLE.
  - The next write can be accepted on the following cycle.
- Hazard: hazard=1 when either condition holds:
  - The write FSM is not in W_IDLE and the latched write line address equals rd_addr[31:OFS].
  - wr_req&wr_rdy this cycle with wr_addr[31:OFS]==rd_addr[31:OFS]. On simultaneous same-line requests the write wins and the read waits.
  - Different-line reads and writes proceed concurrently.
- bus_err: pulses for an erroring response.
  - Read: on the final R beat if any beat of the burst had rresp!=0.
  - Write: with the B handshake if bresp!=0.
  - Data is still delivered or acknowledged normally.
- rid/bid are ignored; one outstanding transaction per direction.

Decomposition:
- Shared cache package holds:
  - AXI constants BURST_INCR=2'b01, SIZE_4B=3'b010, RESP_OKAY=2'b00.
  - Read/write FSM state enums.
  - Line-type typedef parametrised via LINE_WORDS.
- Interface definitions for the cache-side bundle get a LINE_WORDS parameter in the same package file.
- Natural sub-module: line_beat_buffer, a LINE_WORDS x 32 register array with word-indexed write, full-line load and word-indexed read. Instantiated twice (refill assembly, writeback serialisation).

Test Plan:
- LINE_WORDS=4. Refill rd_addr=0x1000_0024, slave returns 0xA0..0xA3 with no stalls:
  - araddr=0x1000_0020, arlen=3.
  - ret_valid pulses 6 cycles after accept.
  - ret_data=0x000000A3_000000A2_000000A1_000000A0.
- Writeback wr_addr=0x2000_0040, line words W0..W3, wready toggling 1/0:
  - Four W beats in order; wlast only on W3.
  - wr_valid pulses exactly once, in the bvalid cycle.
- Simultaneous wr_req 0x3000_0000 and rd_req 0x3000_0008:
  - wr_rdy=1, rd_rdy=0.
  - arvalid stays 0 until the cycle after the B handshake, then the read proceeds.
- Simultaneous write 0x3000_0000 and read 0x4000_0000:
  - Both accepted the same cycle; AR and AW both asserted the next cycle.
- bresp=2'b10 on a writeback, rresp=2'b10 on beat 1 of a refill:
  - bus_err pulses once for each.
  - wr_valid and ret_valid still pulse.
- LINE_WORDS=8, resetn low mid-R_DATA at beat 3:
  - All outputs return to reset values immediately.
  - A new refill after reset completes with 8 beats and arlen=7.
